// File: rtl/ic_74148_sync.sv
// Registered 8-to-3 priority encoder (74148-style) with request edge capture and valid/ack handshake.
// Latency: request edge to pending in SYNC_STAGES+1 edges, to valid/code in SYNC_STAGES+2 edges.
// Backpressure: a presented code is held until ack; new requests accumulate in pending meanwhile.
module ic_74148_sync #(
    // Synchroniser depth on each i_n bit; legal range 1..3.
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ei_n,
    input  logic [7:0] i_n,
    input  logic       ack,
    output logic [2:0] code,
    output logic       valid,
    output logic [7:0] pending,
    output logic [2:0] a_n,
    output logic       gs_n,
    output logic       eo_n
);

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;

    logic [7:0] sync_q [SYNC_STAGES];
    logic [7:0] sync_d [SYNC_STAGES];
    logic [7:0] prev_q, prev_d;
    logic [7:0] pending_q, pending_d;
    state_t     state_q, state_d;
    logic [2:0] code_q, code_d;
    logic [2:0] a_n_q, a_n_d;
    logic       gs_n_q, gs_n_d;
    logic       eo_n_q, eo_n_d;

    logic [7:0] s;
    logic [7:0] fall;
    logic [7:0] set_mask;
    logic [7:0] clr_mask;
    logic       valid_d;

    // Index of the highest set bit; bit 7 has top priority.
    function automatic logic [2:0] prio_idx(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int k = 0; k < 8; k++) begin
            if (v[k]) idx = k[2:0];
        end
        return idx;
    endfunction

    // Synchroniser shift chain plus edge-history register.
    always_comb begin
        sync_d[0] = i_n;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
        s      = sync_q[SYNC_STAGES-1];
        prev_d = s;
        fall   = prev_q & ~s;
    end

    // Handshake FSM, pending set/clear (set wins) and 74148-style output encoding.
    always_comb begin
        state_d  = state_q;
        code_d   = code_q;
        clr_mask = 8'h00;
        set_mask = fall & {8{~ei_n}};

        case (state_q)
            IDLE: begin
                // ack is ignored here; presentation needs the enable and something pending.
                if (!ei_n && (pending_q != 8'h00)) begin
                    code_d  = prio_idx(pending_q);
                    state_d = PRESENT;
                end
            end
            PRESENT: begin
                // Code is frozen; neither new requests nor ei_n affect it until ack.
                if (ack) begin
                    clr_mask = 8'h01 << code_q;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        pending_d = (pending_q & ~clr_mask) | set_mask;
        valid_d   = (state_d == PRESENT);
        a_n_d     = valid_d ? ~code_d : 3'b111;
        gs_n_d    = ~valid_d;
        eo_n_d    = ~(~ei_n & (pending_d == 8'h00));
    end

    // State registers; synchroniser and history reset to "all released".
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= 8'hFF;
            end
            prev_q    <= 8'hFF;
            pending_q <= 8'h00;
            state_q   <= IDLE;
            code_q    <= 3'd0;
            a_n_q     <= 3'b111;
            gs_n_q    <= 1'b1;
            eo_n_q    <= 1'b1;
        end else begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_d[i];
            end
            prev_q    <= prev_d;
            pending_q <= pending_d;
            state_q   <= state_d;
            code_q    <= code_d;
            a_n_q     <= a_n_d;
            gs_n_q    <= gs_n_d;
            eo_n_q    <= eo_n_d;
        end
    end

    assign code    = code_q;
    assign valid   = (state_q == PRESENT);
    assign pending = pending_q;
    assign a_n     = a_n_q;
    assign gs_n    = gs_n_q;
    assign eo_n    = eo_n_q;

endmodule
